// File: rtl/adc_osr_pkg.sv
// adc_osr_pkg
// Shared constants and helpers for the ADC oversampling decimator.
//   OSR_MAX_LOG2   : largest supported log2 of the oversampling ratio
//   DATA_BITS      : width of an ADC conversion result
//   ACC_BITS       : accumulator width. It holds 2^OSR_MAX_LOG2 full-scale
//                    samples, so it can never wrap.
//   window_end_cnt : sample-counter value of the last sample in a window
package adc_osr_pkg;

  localparam int OSR_MAX_LOG2 = 7;
  localparam int DATA_BITS    = 12;
  localparam int ACC_BITS     = DATA_BITS + OSR_MAX_LOG2;

  // A window of 2^osr samples ends when the zero-based counter reaches 2^osr - 1.
  function automatic int unsigned window_end_cnt(input int unsigned osr);
    return (32'd1 << osr) - 32'd1;
  endfunction

endpackage

// File: rtl/adc_osr_fifo.sv
// adc_osr_fifo
// Small synchronous FIFO with a drop-on-full push policy.
// DEPTH must be a power of two (>= 2) so that the pointers wrap naturally.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (clears everything)
//   push      : write push_data this cycle
//   push_data : word to write
//   pop       : remove the head word. It is ignored when the FIFO is empty.
//   head      : oldest stored word; 0 when empty
//   full      : DEPTH words stored
//   empty     : no words stored
//   drop      : a push was discarded because the FIFO was full and no pop
//               freed a slot in the same cycle
module adc_osr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             drop
);
  import adc_osr_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic pop_ok;
  logic push_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // When the FIFO is full, a pop in the same cycle frees the head slot.
  // The new word goes into that slot (wr_ptr == rd_ptr when full), so a
  // simultaneous push is accepted.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The head is read straight from the storage registers. It stays stable
  // until a pop advances rd_ptr, and it reads as zero when nothing is stored.
  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/adc_osr_decimator.sv
// adc_osr_decimator
// Accumulates 2^k consecutive ADC results (k = 0..OSR_MAX_LOG2, latched at
// window start). It emits one left-aligned OUT_BITS word per window into an
// output FIFO.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   data_in           : conversion result, sampled on the strobe's first cycle
//   data_valid_in     : conversion-finished strobe (a multi-cycle high counts once)
//   osr_control_in    : requested log2 oversampling ratio, clamped to OSR_MAX_LOG2
//   clear_overflow_in : clears the sticky overflow flag (a new drop wins)
//   data_out          : FIFO head word, 0 when empty
//   data_valid_out    : FIFO not empty
//   data_ready_in     : consumer ready
//   overflow_out      : sticky flag, set when a word was dropped on a full FIFO
//
// Output handshake: a word transfers on every rising edge where
// data_valid_out and data_ready_in are both high. While data_valid_out is
// high and no transfer happens, data_out holds its value. data_ready_in is
// ignored while data_valid_out is low.
module adc_osr_decimator #(
  parameter int DATA_BITS    = 12,
  parameter int OUT_BITS     = 16,
  parameter int OSR_MAX_LOG2 = 7,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid_in,
  input  logic [2:0]           osr_control_in,
  input  logic                 clear_overflow_in,
  output logic [OUT_BITS-1:0]  data_out,
  output logic                 data_valid_out,
  input  logic                 data_ready_in,
  output logic                 overflow_out
);
  import adc_osr_pkg::*;

  localparam int         ACC_W   = DATA_BITS + OSR_MAX_LOG2;
  localparam int         CNT_W   = (OSR_MAX_LOG2 > 0) ? OSR_MAX_LOG2 : 1;
  localparam logic [2:0] OSR_MAX = 3'(OSR_MAX_LOG2);

  // Registered state
  logic             valid_d;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       osr_r;

  // Combinational datapath
  logic             sample_en;
  logic             window_start;
  logic             window_end;
  logic [2:0]       osr_clamped;
  logic [2:0]       osr_eff;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] aligned;
  logic [OUT_BITS-1:0] word;

  // FIFO interface
  logic fifo_pop;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_drop;

  // Rising-edge detect. The ADC holds its strobe for more than one cycle,
  // so only the first high cycle is used.
  assign sample_en   = data_valid_in & ~valid_d;
  assign osr_clamped = (osr_control_in > OSR_MAX) ? OSR_MAX : osr_control_in;

  always_comb begin
    window_start = (cnt == '0);
    // The first sample of a window already uses the ratio being latched,
    // so a 1-sample window (k=0) closes on the same sample it opens with.
    osr_eff      = window_start ? osr_clamped : osr_r;
    acc_next     = window_start ? ACC_W'(data_in) : acc + ACC_W'(data_in);
    window_end   = sample_en && (cnt == CNT_W'(window_end_cnt(int'(osr_eff))));
    // Shift the sum into the top of the accumulator range, then keep the
    // upper OUT_BITS (plain truncation).
    aligned      = acc_next << (OSR_MAX - osr_eff);
    word         = aligned[ACC_W-1 -: OUT_BITS];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_d <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      osr_r   <= '0;
    end else begin
      valid_d <= data_valid_in;
      if (sample_en) begin
        if (window_start) begin
          osr_r <= osr_clamped;
        end
        acc <= acc_next;
        cnt <= window_end ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  // Sticky overflow. A drop in the same cycle as a clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_out <= 1'b0;
    end else if (fifo_drop) begin
      overflow_out <= 1'b1;
    end else if (clear_overflow_in) begin
      overflow_out <= 1'b0;
    end
  end

  assign fifo_pop       = data_valid_out & data_ready_in;
  assign data_valid_out = ~fifo_empty;

  adc_osr_fifo #(
    .WIDTH (OUT_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (window_end),
    .push_data (word),
    .pop       (fifo_pop),
    .head      (data_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  // A word can only be dropped when the FIFO reports full.
  drop_only_when_full: assert property (@(posedge clk) disable iff (rst)
    fifo_drop |-> fifo_full);

endmodule
